// File: rtl/bcd_sched_pkg.sv
// rtl/bcd_sched_pkg.sv - shared states, default sizes and the double-dabble digit adjust
package bcd_sched_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int BIN_W_DEF  = 12;
  localparam int DIGITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_convert_scheduler_if.sv
// rtl/bcd_convert_scheduler_if.sv - requester-side bus of the shared BCD conversion scheduler
interface bcd_convert_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*BIN_W-1:0] bin_in;
  logic                   busy;
  logic [IDW-1:0]         grant_id;
  logic                   done;
  logic [IDW-1:0]         done_id;
  logic [4*DIGITS-1:0]    bcd_out;

  modport master (output req, bin_in, input busy, grant_id, done, done_id, bcd_out);
  modport slave  (input req, bin_in, output busy, grant_id, done, done_id, bcd_out);
endinterface

// File: rtl/bcd_dabble_core.sv
// rtl/bcd_dabble_core.sv - shift-and-add-3 engine holding the BCD and binary shift registers
module bcd_dabble_core
  import bcd_sched_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                shift_en,
  input  logic [BIN_W-1:0]    bin,
  output logic [4*DIGITS-1:0] bcd
);

  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj;
  logic [BIN_W-1:0]    bin_q;

  always_comb begin
    adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      adj[4*k +: 4] = add3(bcd_q[4*k +: 4]);
    end
  end

  // bcd is the value the register takes on a shift edge, so the finished result
  // can be captured on the same edge as the last shift.
  assign bcd = {adj[4*DIGITS-2:0], bin_q[BIN_W-1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_q <= '0;
      bin_q <= '0;
    end else if (load) begin
      bcd_q <= '0;
      bin_q <= bin;
    end else if (shift_en) begin
      bcd_q <= bcd;
      bin_q <= {bin_q[BIN_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/bcd_convert_scheduler.sv
// rtl/bcd_convert_scheduler.sv - round-robin arbiter sharing one binary-to-BCD engine
// Optional per-requester result bank: BCD_SCHED_CACHE_EN.
module bcd_convert_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  bcd_convert_scheduler_if.slave    bus
`ifdef BCD_SCHED_CACHE_EN
  ,
  output logic [N_REQ*4*DIGITS-1:0] result_cache
`endif
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(BIN_W);
  localparam int BW  = 4 * DIGITS;
  localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(BIN_W - 1);
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] grant_q, grant_d, last_q, last_d, done_id_q, done_id_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [BW-1:0]  bcd_out_q, bcd_out_d;
  logic [BW-1:0]  core_bcd;
  logic [IDW-1:0] win;
  logic           found;
  int             idx;

  // First set request at or after last_q+1, wrapping.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  bcd_dabble_core #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == ST_IDLE && found),
    .shift_en (state_q == ST_SHIFT),
    .bin      (bus.bin_in[win*BIN_W +: BIN_W]),
    .bcd      (core_bcd)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = done_q;
    done_id_d = done_id_q;
    bcd_out_d = bcd_out_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          grant_d = win;
          last_d  = win;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          done_id_d = grant_q;
          bcd_out_d = core_bcd;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      grant_q   <= '0;
      last_q    <= LAST_RST;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      bcd_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      bcd_out_q <= bcd_out_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;
  assign bus.done     = done_q;
  assign bus.done_id  = done_id_q;
  assign bus.bcd_out  = bcd_out_q;

`ifdef BCD_SCHED_CACHE_EN
  logic [N_REQ*BW-1:0] cache_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_q <= '0;
    end else if (state_q == ST_DONE) begin
      cache_q[done_id_q*BW +: BW] <= bcd_out_q;
    end
  end

  assign result_cache = cache_q;
`endif

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// tb/tb_bcd_convert_scheduler.sv - scoreboard bench for the shared BCD conversion scheduler
module tb_bcd_convert_scheduler;

  localparam int N = 4;
  localparam int W = 12;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bcd_convert_scheduler_if #(.N_REQ(N), .BIN_W(W), .DIGITS(D)) bus ();
`ifdef BCD_SCHED_CACHE_EN
  logic [N*4*D-1:0] result_cache;
`endif

  bcd_convert_scheduler #(.N_REQ(N), .BIN_W(W), .DIGITS(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BCD_SCHED_CACHE_EN
    ,
    .result_cache (result_cache)
`endif
  );

  typedef struct {
    logic [1:0]  id;
    logic [15:0] bcd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  task automatic expect_result(input int id, input logic [15:0] bcd);
    exp_t e;
    e.id  = id[1:0];
    e.bcd = bcd;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual id=%0d bcd=%h required no done", bus.done_id, bus.bcd_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_id", 32'(bus.done_id), 32'(e.id));
        check("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Single requester: grant on the next edge, done 12 cycles after grant, busy for 13.
  task automatic run_single(input int id, input logic [11:0] v, input logic [15:0] e);
    int lat;
    int bb;
    bit got;
    lat = 0;
    bb  = 0;
    got = 1'b0;
    @(negedge clk);
    bus.bin_in[id*W +: W] = v;
    bus.req[id] = 1'b1;
    expect_result(id, e);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (c == 0) check("grant_id", 32'(bus.grant_id), 32'(id));
      if (bus.busy) bb++;
      if (bus.done) got = 1'b1;
    end
    bus.req[id] = 1'b0;
    check("done_seen", 32'(got), 1);
    check("done_latency", 32'(lat - 1), 12);
    check("busy_cycles", 32'(bb), 13);
    @(negedge clk);
    check("busy_after_done", 32'(bus.busy), 0);
    check("done_pulse_width", 32'(bus.done), 0);
  endtask

  task automatic wait_dones(input int n, input bit drop);
    int seen;
    int last;
    int cyc;
    seen = 0;
    last = -1;
    cyc  = 0;
    while (seen < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        if (last >= 0) check("done_spacing", 32'(cyc - last), 14);
        last = cyc;
        seen++;
        if (drop) bus.req[bus.done_id] = 1'b0;
      end
    end
    check("dones_seen", 32'(seen), 32'(n));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt;
    bus.req    = '0;
    bus.bin_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_grant_id", 32'(bus.grant_id), 0);
    check("rst_done_id", 32'(bus.done_id), 0);
    check("rst_bcd_out", 32'(bus.bcd_out), 0);

    run_single(0, 12'd4095, 16'h4095);

    do_reset();
    @(negedge clk);
    bus.bin_in = {12'd4094, 12'd1000, 12'd9, 12'd0};
    bus.req    = 4'b1111;
    expect_result(0, 16'h0000);
    expect_result(1, 16'h0009);
    expect_result(2, 16'h1000);
    expect_result(3, 16'h4094);
    expect_result(0, 16'h0000);
    wait_dones(5, 1'b0);
    bus.req = '0;

    // Requester 2 drops its request during the third shift cycle.
    repeat (3) @(negedge clk);
    bus.bin_in[2*W +: W] = 12'd1234;
    bus.req[2] = 1'b1;
    expect_result(2, 16'h1234);
    repeat (3) @(negedge clk);
    bus.req[2] = 1'b0;
    wait_dones(1, 1'b0);
    bcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
    end
    check("no_regrant_busy", 32'(bcnt), 0);

    // Reset during shift cycle 5 aborts the conversion silently.
    bus.bin_in[1*W +: W] = 12'd77;
    bus.req[1] = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    bus.req[1] = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_grant_id", 32'(bus.grant_id), 0);
    check("abort_bcd_out", 32'(bus.bcd_out), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    run_single(3, 12'd42, 16'h0042);

    do_reset();
    @(negedge clk);
    bus.bin_in[0*W +: W] = 12'd5;
    bus.bin_in[3*W +: W] = 12'd8;
    bus.req[0] = 1'b1;
    bus.req[3] = 1'b1;
    expect_result(0, 16'h0005);
    expect_result(3, 16'h0008);
    wait_dones(2, 1'b1);

    // After requester 1 is served, requester 3 outranks it.
    run_single(1, 12'd300, 16'h0300);
    @(negedge clk);
    bus.bin_in[3*W +: W] = 12'd2048;
    bus.req[1] = 1'b1;
    bus.req[3] = 1'b1;
    expect_result(3, 16'h2048);
    expect_result(1, 16'h0300);
    wait_dones(2, 1'b1);

`ifdef BCD_SCHED_CACHE_EN
    do_reset();
    run_single(2, 12'd1234, 16'h1234);
    run_single(0, 12'd567, 16'h0567);
    check("cache_slot0", 32'(result_cache[0*16 +: 16]), 32'h0567);
    check("cache_slot1", 32'(result_cache[1*16 +: 16]), 32'h0000);
    check("cache_slot2", 32'(result_cache[2*16 +: 16]), 32'h1234);
    check("cache_slot3", 32'(result_cache[3*16 +: 16]), 32'h0000);
`endif

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
